// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-read-port register file with forwarding, pending-write scoreboard and debug port
module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     wen_i,
    input  logic [ADDR_W-1:0]        waddr_i,
    input  logic [DATA_W-1:0]        wdata_i,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr_i,
    output logic [NUM_RD*DATA_W-1:0] rd_data_o,
    output logic [NUM_RD-1:0]        rd_busy_o,
    input  logic                     sb_set_i,
    input  logic [ADDR_W-1:0]        sb_addr_i,
    input  logic                     dbg_req_i,
    input  logic                     dbg_we_i,
    input  logic [ADDR_W-1:0]        dbg_addr_i,
    input  logic [DATA_W-1:0]        dbg_wdata_i,
    output logic                     dbg_gnt_o,
    output logic                     dbg_rvalid_o,
    output logic [DATA_W-1:0]        dbg_rdata_o,
    output logic                     dbg_stall_o
);
    localparam int NUM_REGS = 2 ** ADDR_W;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] STALL  = 2'd1;
    localparam logic [1:0] ACCESS = 2'd2;
    localparam logic [1:0] RESP   = 2'd3;

    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [NUM_REGS-1:0] sb_q;
    logic [NUM_REGS-1:0] sb_d;
    logic [1:0]          st_q;
    logic [1:0]          st_eff;
    logic [1:0]          st_d;
    logic [DATA_W-1:0]   dbg_rd_val;
    logic                dbg_access;

    function automatic logic is_zero(input logic [ADDR_W-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    function automatic logic [DATA_W-1:0] read_rule(
        input logic [ADDR_W-1:0] a,
        input logic              wen,
        input logic [ADDR_W-1:0] waddr,
        input logic [DATA_W-1:0] wdata,
        input logic [DATA_W-1:0] stored
    );
        if (is_zero(a))
            return '0;
        else if (wen && (waddr == a))
            return wdata;
        else
            return stored;
    endfunction

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        assign ra = rd_addr_i[k*ADDR_W +: ADDR_W];
        assign rd_data_o[k*DATA_W +: DATA_W] = read_rule(ra, wen_i, waddr_i, wdata_i, regs_q[ra]);
        assign rd_busy_o[k] = sb_q[ra] & ~(wen_i & (waddr_i == ra));
    end

    assign dbg_rd_val = read_rule(dbg_addr_i, wen_i, waddr_i, wdata_i, regs_q[dbg_addr_i]);

    // st_eff is the state the port is in this cycle once the live request and
    // writeback are taken into account, so an idle request with no writeback
    // is granted in the same cycle it is raised.
    always_comb begin
        st_eff = st_q;
        if (!rst_n_i) begin
            st_eff = IDLE;
        end else begin
            case (st_q)
                IDLE:    if (dbg_req_i) st_eff = wen_i ? STALL : ACCESS;
                STALL:   if (!wen_i) st_eff = ACCESS;
                default: st_eff = st_q;
            endcase
        end
        st_d = st_eff;
        case (st_eff)
            ACCESS:  st_d = RESP;
            RESP:    st_d = IDLE;
            default: st_d = st_eff;
        endcase
    end

    assign dbg_access   = (st_eff == ACCESS);
    assign dbg_gnt_o    = dbg_access;
    assign dbg_stall_o  = (st_eff == STALL) || (st_eff == ACCESS);
    assign dbg_rvalid_o = (st_q == RESP);

    always_comb begin
        sb_d = sb_q;
        if (wen_i) sb_d[waddr_i] = 1'b0;
        if (sb_set_i && !is_zero(sb_addr_i)) sb_d[sb_addr_i] = 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            st_q        <= IDLE;
            sb_q        <= '0;
            dbg_rdata_o <= '0;
        end else begin
            st_q <= st_d;
            sb_q <= sb_d;
            if (dbg_access && !dbg_we_i) dbg_rdata_o <= dbg_rd_val;
        end
    end

    // Core write is placed last so it overrides a same-address debug write.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else begin
            if (dbg_access && dbg_we_i && !is_zero(dbg_addr_i)) regs_q[dbg_addr_i] <= dbg_wdata_i;
            if (wen_i && !is_zero(waddr_i)) regs_q[waddr_i] <= wdata_i;
        end
    end
endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - scoreboard bench for regfile_mp with random and directed traffic
module tb_regfile_mp;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wen = 1'b0;
    logic [4:0]  waddr = '0;
    logic [31:0] wdata = '0;
    logic [9:0]  rd_addr = '0;
    logic [63:0] rd_data;
    logic [1:0]  rd_busy;
    logic        sb_set = 1'b0;
    logic [4:0]  sb_addr = '0;
    logic        dbg_req = 1'b0;
    logic        dbg_we = 1'b0;
    logic [4:0]  dbg_addr = '0;
    logic [31:0] dbg_wdata = '0;
    logic        dbg_gnt;
    logic        dbg_rvalid;
    logic [31:0] dbg_rdata;
    logic        dbg_stall;

    regfile_mp dut (
        .clk_i(clk), .rst_n_i(rst_n), .wen_i(wen), .waddr_i(waddr), .wdata_i(wdata),
        .rd_addr_i(rd_addr), .rd_data_o(rd_data), .rd_busy_o(rd_busy),
        .sb_set_i(sb_set), .sb_addr_i(sb_addr),
        .dbg_req_i(dbg_req), .dbg_we_i(dbg_we), .dbg_addr_i(dbg_addr), .dbg_wdata_i(dbg_wdata),
        .dbg_gnt_o(dbg_gnt), .dbg_rvalid_o(dbg_rvalid), .dbg_rdata_o(dbg_rdata), .dbg_stall_o(dbg_stall)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] data;
        logic [1:0]  busy;
        logic        gnt;
        logic        stall;
        logic        rvalid;
    } exp_t;

    exp_t        exp_q [$];
    logic [31:0] dbg_q [$];
    logic [31:0] mregs [32];
    logic        msb [32];
    logic        resp_pending = 1'b0;
    logic [31:0] last_rdata = '0;
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mread(input logic [4:0] a);
        if (a == 0) return 32'h0;
        if (wen && waddr == a) return wdata;
        return mregs[a];
    endfunction

    function automatic logic mbusy(input logic [4:0] a);
        return msb[a] && !(wen && waddr == a);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            mregs[i] = '0;
            msb[i] = 1'b0;
        end
        resp_pending = 1'b0;
        last_rdata = '0;
    endtask

    // Push this cycle's expectations, step one clock, then advance the model.
    task automatic cycle();
        exp_t e;
        logic g;
        g = dbg_req && !resp_pending && !wen;
        e.data   = {mread(rd_addr[9:5]), mread(rd_addr[4:0])};
        e.busy   = {mbusy(rd_addr[9:5]), mbusy(rd_addr[4:0])};
        e.gnt    = g;
        e.stall  = dbg_req && !resp_pending;
        e.rvalid = resp_pending;
        exp_q.push_back(e);
        @(posedge clk);
        if (g) begin
            if (!dbg_we) last_rdata = mread(dbg_addr);
            else if (dbg_addr != 0) mregs[dbg_addr] = dbg_wdata;
            dbg_q.push_back(last_rdata);
        end
        if (wen && waddr != 0) mregs[waddr] = wdata;
        if (wen) msb[waddr] = 1'b0;
        if (sb_set && sb_addr != 0) msb[sb_addr] = 1'b1;
        resp_pending = g;
        #1;
        if (g) dbg_req = 1'b0;
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("rd_data", rd_data, e.data);
            chk("rd_busy", {62'b0, rd_busy}, {62'b0, e.busy});
            chk("dbg_gnt", {63'b0, dbg_gnt}, {63'b0, e.gnt});
            chk("dbg_stall", {63'b0, dbg_stall}, {63'b0, e.stall});
            chk("dbg_rvalid", {63'b0, dbg_rvalid}, {63'b0, e.rvalid});
        end
        if (dbg_rvalid && rst_n) begin
            if (dbg_q.size() == 0) chk("dbg_rvalid_unexpected", 64'd1, 64'd0);
            else chk("dbg_rdata", {32'b0, dbg_rdata}, {32'b0, dbg_q.pop_front()});
        end
    end

    task automatic idle_inputs();
        wen = 1'b0;
        sb_set = 1'b0;
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_gnt", {63'b0, dbg_gnt}, 64'd0);
        chk("reset_rdata", {32'b0, dbg_rdata}, 64'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            rd_addr = {5'(31 - i), 5'(i)};
            cycle();
        end

        // forwarding of x5
        wen = 1; waddr = 5; wdata = 32'hDEADBEEF; rd_addr = {5'd5, 5'd0};
        cycle();
        wen = 0;
        cycle();

        // x0 via core and via debug, with an attempted scoreboard set
        wen = 1; waddr = 0; wdata = 32'h1234; sb_set = 1; sb_addr = 0; rd_addr = {5'd0, 5'd0};
        cycle();
        idle_inputs();
        dbg_req = 1; dbg_we = 1; dbg_addr = 0; dbg_wdata = 32'h1234;
        repeat (3) cycle();

        // scoreboard set, forwarded clear, and set-wins collision on x7
        sb_set = 1; sb_addr = 7; rd_addr = {5'd7, 5'd0};
        cycle();
        sb_set = 0;
        repeat (2) cycle();
        wen = 1; waddr = 7; wdata = 32'h7777_0007;
        cycle();
        wen = 0;
        cycle();
        wen = 1; waddr = 7; wdata = 32'h7777_0008; sb_set = 1; sb_addr = 7;
        cycle();
        idle_inputs();
        repeat (2) cycle();

        // debug read of x3 stalled behind three writebacks
        wen = 1; waddr = 3; wdata = 32'h3333_CAFE;
        cycle();
        dbg_req = 1; dbg_we = 0; dbg_addr = 3; waddr = 10; wdata = 32'h1010_1010;
        repeat (3) cycle();
        wen = 0;
        repeat (3) cycle();

        // debug write of x9 then core-port readback
        dbg_req = 1; dbg_we = 1; dbg_addr = 9; dbg_wdata = 32'hA5A5A5A5; rd_addr = {5'd0, 5'd9};
        repeat (3) cycle();

        for (int n = 0; n < 600; n++) begin
            wen = ($urandom % 3) == 0;
            waddr = 5'($urandom_range(0, 7));
            wdata = $urandom;
            rd_addr = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            sb_set = ($urandom % 4) == 0;
            sb_addr = 5'($urandom_range(0, 7));
            if (!dbg_req && !resp_pending && ($urandom % 6) == 0) begin
                dbg_req = 1;
                dbg_we = $urandom % 2;
                dbg_addr = 5'($urandom_range(0, 7));
                dbg_wdata = $urandom;
            end
            cycle();
        end
        idle_inputs();
        dbg_req = 0;
        repeat (2) cycle();
        chk("dbg_queue_drained", 64'(dbg_q.size()), 64'd0);

        // reset pulled during a debug write access
        dbg_req = 1; dbg_we = 1; dbg_addr = 9; dbg_wdata = 32'h5A5A5A5A; rd_addr = {5'd9, 5'd9};
        #1;
        chk("abort_gnt_before", {63'b0, dbg_gnt}, 64'd1);
        rst_n = 0;
        #1;
        chk("abort_gnt", {63'b0, dbg_gnt}, 64'd0);
        chk("abort_stall", {63'b0, dbg_stall}, 64'd0);
        chk("abort_rd_x9", rd_data, 64'd0);
        dbg_req = 0;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1;
        repeat (2) cycle();
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
